// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the downstream-FIFO write arbiter.
// The state enum and the default requester/burst constants live here.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_FIFO_WIDTH = 32;
    localparam int DEF_MAX_BURST  = 16;

    // Width of an index into a vector of n entries; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot winner is the first set request
// at or above ptr, wrapping past the top index.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((32'(ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that lets one requester at a time burst beats into a
// downstream sync FIFO; ownership ends on a pushed last beat or at MAX_BURST.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    input  logic [NUM_REQ-1:0][FIFO_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]                 req_last_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    input  logic                               full_i,
    output logic                               push_o,
    output logic [FIFO_WIDTH-1:0]              wr_data_o,
    output logic [NUM_REQ-1:0]                 grant_o,
    output logic                               busy_o
);

    localparam int PTR_W = idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e         state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [PTR_W-1:0]   owner_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [NUM_REQ-1:0] win;
    logic [PTR_W-1:0]   win_idx;
    logic               push;
    logic               release_beat;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [PTR_W-1:0]   ptr_nxt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req   (req_valid_i),
        .ptr   (ptr_q),
        .grant (win)
    );

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win[i]) win_idx = PTR_W'(i);
        end
    end

    // Owner datapath is purely combinational so a beat moves in the cycle it is offered.
    always_comb begin
        push         = (state_q == GRANT) && req_valid_i[owner_q] && !full_i;
        wr_data_o    = push ? req_data_i[owner_q] : '0;
        req_ready_o  = ((state_q == GRANT) && !full_i) ? grant_q : '0;
        cnt_nxt      = cnt_q + CNT_W'(1);
        release_beat = push && (req_last_i[owner_q] || (cnt_nxt == CNT_W'(MAX_BURST)));
        ptr_nxt      = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_valid_i) begin
                        state_q <= GRANT;
                        grant_q <= win;
                        owner_q <= win_idx;
                        cnt_q   <= '0;
                    end
                end
                GRANT: begin
                    if (release_beat) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        ptr_q   <= ptr_nxt;
                        cnt_q   <= '0;
                    end else if (push) begin
                        cnt_q <= cnt_nxt;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign push_o  = push;
    assign grant_o = grant_q;
    assign busy_o  = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized bench for fifo_wr_arbiter, checked cycle by cycle
// against a transaction-level model of the arbitration rules.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int W     = 32;
    localparam int MB    = 16;
    localparam int DEPTH = 256;

    logic                clk  = 1'b0;
    logic                rstn = 1'b1;
    logic [N-1:0]        valid;
    logic [N-1:0][W-1:0] data;
    logic [N-1:0]        last;
    logic [N-1:0]        ready;
    logic                full;
    logic                push;
    logic [W-1:0]        wr_data;
    logic [N-1:0]        grant;
    logic                busy;

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .FIFO_WIDTH (W),
        .MAX_BURST  (MB)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .req_valid_i (valid),
        .req_data_i  (data),
        .req_last_i  (last),
        .req_ready_o (ready),
        .full_i      (full),
        .push_o      (push),
        .wr_data_o   (wr_data),
        .grant_o     (grant),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-requester beat sources (data, last) with head/tail counters.
    logic [W-1:0] sd [N][DEPTH];
    logic         sl [N][DEPTH];
    int           hd [N];
    int           tl [N];
    logic [N-1:0] hold;

    // Reference model: owner = -1 when nobody holds the FIFO.
    int   m_owner, m_ptr, m_cnt, m_pushes;
    logic prev_busy;

    logic [W-1:0] push_log  [$];
    logic [N-1:0] grant_log [$];
    logic [W-1:0] exp_p     [$];
    logic [N-1:0] exp_g     [$];

    function automatic logic [W-1:0] mk(int r, int p, int b);
        return W'((r << 24) | (p << 16) | b);
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic enqueue(int r, int len, int p, bit term);
        for (int b = 0; b < len; b++) begin
            sd[r][tl[r] % DEPTH] = mk(r, p, b);
            sl[r][tl[r] % DEPTH] = term && (b == len - 1);
            tl[r]++;
        end
    endtask

    function automatic bit pending();
        for (int r = 0; r < N; r++) if (hd[r] < tl[r]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_owner   = -1;
        m_ptr     = 0;
        m_cnt     = 0;
        prev_busy = 1'b0;
    endtask

    task automatic drive_inputs();
        for (int r = 0; r < N; r++) begin
            if (hd[r] < tl[r] && !hold[r]) begin
                valid[r] = 1'b1;
                data[r]  = sd[r][hd[r] % DEPTH];
                last[r]  = sl[r][hd[r] % DEPTH];
            end else begin
                valid[r] = 1'b0;
                data[r]  = W'($urandom);
                last[r]  = 1'($urandom);
            end
        end
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_ready"}, ready, 0);
        chk({tag, "_push"}, push, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
    endtask

    // One clock: drive at negedge, compare at +1, advance the model across posedge.
    task automatic cycle();
        logic [N-1:0] e_grant, e_ready;
        logic         e_busy, e_push;
        logic [W-1:0] e_data;
        int           c;
        drive_inputs();
        #1;
        e_busy  = (m_owner >= 0);
        e_grant = e_busy ? N'(1 << m_owner) : '0;
        e_ready = (e_busy && !full) ? e_grant : '0;
        e_push  = e_busy ? (valid[m_owner] && !full) : 1'b0;
        e_data  = e_push ? data[m_owner] : '0;
        chk("busy", busy, e_busy);
        chk("grant", grant, e_grant);
        chk("ready", ready, e_ready);
        chk("push", push, e_push);
        chk("wr_data", wr_data, e_data);
        if (push === 1'b1) push_log.push_back(wr_data);
        if (busy === 1'b1 && prev_busy !== 1'b1) grant_log.push_back(grant);
        prev_busy = busy;
        if (!e_busy) begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (valid[c]) begin
                    m_owner = c;
                    m_cnt   = 0;
                    break;
                end
            end
        end else if (e_push) begin
            hd[m_owner]++;
            m_cnt++;
            m_pushes++;
            if (last[m_owner] || m_cnt == MB) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_cnt   = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_until(int n, int budget);
        int target;
        int k;
        target = m_pushes + n;
        k      = 0;
        while (m_pushes < target && k < budget) begin
            cycle();
            k++;
        end
        chk("run_until_timeout", m_pushes >= target, 1);
    endtask

    task automatic drain(int budget, output int cyc);
        cyc = 0;
        while ((pending() || m_owner >= 0) && cyc < budget) begin
            cycle();
            cyc++;
        end
        chk("drain_timeout", !(pending() || m_owner >= 0), 1);
    endtask

    task automatic cmp_logs(string tag);
        chk({tag, "_push_count"}, push_log.size(), exp_p.size());
        for (int i = 0; i < exp_p.size(); i++)
            chk({tag, "_push_data"}, (i < push_log.size()) ? push_log[i] : {W{1'bx}}, exp_p[i]);
        chk({tag, "_grant_count"}, grant_log.size(), exp_g.size());
        for (int i = 0; i < exp_g.size(); i++)
            chk({tag, "_grant_order"}, (i < grant_log.size()) ? grant_log[i] : {N{1'bx}}, exp_g[i]);
    endtask

    task automatic new_scenario();
        push_log.delete();
        grant_log.delete();
        exp_p.delete();
        exp_g.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int n0;
        int r;
        int pk;
        valid    = '0;
        data     = '0;
        last     = '0;
        full     = 1'b0;
        hold     = '0;
        m_pushes = 0;
        for (int i = 0; i < N; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        model_reset();

        rstn = 1'b0;
        #1;
        check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Requesters 0 and 2 together, 3 beats each: 0 first, then 2.
        new_scenario();
        enqueue(0, 3, 1, 1'b1);
        enqueue(2, 3, 1, 1'b1);
        drain(40, cyc);
        for (int b = 0; b < 3; b++) exp_p.push_back(mk(0, 1, b));
        for (int b = 0; b < 3; b++) exp_p.push_back(mk(2, 1, b));
        exp_g.push_back(4'b0001);
        exp_g.push_back(4'b0100);
        cmp_logs("s1");

        // Five full cycles in the middle of a 4-beat burst from requester 1.
        new_scenario();
        enqueue(1, 4, 2, 1'b1);
        run_until(2, 20);
        full = 1'b1;
        n0   = push_log.size();
        repeat (5) cycle();
        chk("s2_stall_pushes", push_log.size() - n0, 0);
        full = 1'b0;
        drain(40, cyc);
        for (int b = 0; b < 4; b++) exp_p.push_back(mk(1, 2, b));
        exp_g.push_back(4'b0010);
        cmp_logs("s2");

        // 20 beats without last: split at MAX_BURST, then a terminating beat.
        new_scenario();
        enqueue(1, 20, 3, 1'b0);
        enqueue(1, 1, 4, 1'b1);
        drain(100, cyc);
        for (int b = 0; b < 20; b++) exp_p.push_back(mk(1, 3, b));
        exp_p.push_back(mk(1, 4, 0));
        exp_g.push_back(4'b0010);
        exp_g.push_back(4'b0010);
        cmp_logs("s3");

        // Asynchronous reset during the third beat of a burst from requester 3.
        new_scenario();
        enqueue(3, 5, 5, 1'b1);
        run_until(2, 20);
        drive_inputs();
        #1;
        chk("s5_mid_push", push, 1);
        #1;
        rstn = 1'b0;
        #1;
        check_zero("s5_async");
        for (int i = 0; i < N; i++) hd[i] = tl[i];
        model_reset();
        drive_inputs();
        @(negedge clk);
        @(negedge clk);
        check_zero("s5_held");
        rstn = 1'b1;
        new_scenario();
        enqueue(3, 1, 9, 1'b1);
        enqueue(0, 1, 9, 1'b1);
        drain(20, cyc);
        exp_p.push_back(mk(0, 9, 0));
        exp_p.push_back(mk(3, 9, 0));
        exp_g.push_back(4'b0001);
        exp_g.push_back(4'b1000);
        cmp_logs("s5");

        // All four requesters continuously valid with single-beat packets.
        new_scenario();
        for (int i = 0; i < N; i++) begin
            enqueue(i, 1, 6, 1'b1);
            enqueue(i, 1, 7, 1'b1);
        end
        drain(60, cyc);
        chk("s4_cycles", cyc, 16);
        for (int p = 6; p <= 7; p++) begin
            for (int i = 0; i < N; i++) begin
                exp_p.push_back(mk(i, p, 0));
                exp_g.push_back(N'(1 << i));
            end
        end
        cmp_logs("s4");

        // Owner drops valid for 3 cycles while another requester waits.
        new_scenario();
        enqueue(2, 6, 8, 1'b1);
        run_until(2, 20);
        enqueue(0, 2, 8, 1'b1);
        hold[2] = 1'b1;
        n0      = push_log.size();
        repeat (3) cycle();
        chk("s6_gap_pushes", push_log.size() - n0, 0);
        hold = '0;
        drain(60, cyc);
        for (int b = 0; b < 6; b++) exp_p.push_back(mk(2, 8, b));
        for (int b = 0; b < 2; b++) exp_p.push_back(mk(0, 8, b));
        exp_g.push_back(4'b0100);
        exp_g.push_back(4'b0001);
        cmp_logs("s6");

        // Random traffic, backpressure and valid gaps against the model.
        pk = 10;
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                r = int'($urandom_range(0, N - 1));
                if (tl[r] - hd[r] < 100) begin
                    enqueue(r, int'($urandom_range(1, 20)), pk % 256, 1'b1);
                    pk++;
                end
            end
            full = ($urandom_range(0, 3) == 0);
            hold = N'($urandom & $urandom & $urandom);
            cycle();
        end
        full = 1'b0;
        hold = '0;
        drain(3000, cyc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
